mult_datapath: RTL and testbench

Register/arithmetic datapath for the 8-bit signed shift-add multiplier. It consumes the `Clr_Ld`, `Shift`, `Add` and `Sub` strobes from the multiplier controller and returns `M` (the current multiplier LSB) to it. It holds the sign-extension bit X, accumulator A and multiplier B, and adds or subtracts the switch operand S each step. {A,B} holds the 16-bit two's-complement product after 8 shift steps.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_datapath_adder9.sv | 43 ++++
 rtl/mult_datapath.sv | 95 +++++++++
 tb/tb_mult_datapath.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier (datapath and controller).
package mult_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLRLD,
    OP_SHIFT,
    OP_ARITH
  } dp_op_t;

endpackage

// File: rtl/mult_datapath_adder9.sv
// Ripple-carry adder built from full-adder cells; carry out of the MSB is discarded.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

module adder9 #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s
);

  logic [N-1:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N - 1; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  // MSB stage needs only the sum; its carry would be thrown away.
  assign s[N-1] = a[N-1] ^ b[N-1] ^ carry[N-1];

endmodule

// File: rtl/mult_datapath.sv
// X/A/B register datapath of the signed shift-add multiplier with add/sub-then-shift per edge.
module mult_datapath #(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_Ld,
  input  logic             Shift,
  input  logic             Add,
  input  logic             Sub,
  input  logic [WIDTH-1:0] S,
  output logic             M,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X
);

  import mult_pkg::*;

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             add_en, sub_en, arith_en;
  logic [WIDTH:0]   a_ext, s_ext, opnd, adder_sum, sum;
  dp_op_t           op;

  // Sub wins over Add; both are qualified by the current multiplier LSB.
  always_comb begin
    add_en   = Add & ~Sub & b_q[0];
    sub_en   = Sub & b_q[0];
    arith_en = add_en | sub_en;
    a_ext    = {a_q[WIDTH-1], a_q};
    s_ext    = {S[WIDTH-1], S};
    opnd     = sub_en ? ~s_ext : s_ext;
  end

  adder9 #(.N(WIDTH + 1)) u_adder (
    .a   (a_ext),
    .b   (opnd),
    .cin (sub_en),
    .s   (adder_sum)
  );

  always_comb begin
    sum = arith_en ? adder_sum : {x_q, a_q};

    if (Clr_Ld)        op = OP_CLRLD;
    else if (Shift)    op = OP_SHIFT;
    else if (arith_en) op = OP_ARITH;
    else               op = OP_HOLD;
  end

  always_comb begin
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    case (op)
      OP_CLRLD: begin
        x_d = 1'b0;
        a_d = '0;
        b_d = S;
      end
      OP_SHIFT: begin
        // Arithmetic shift of {sum, B}: sum[WIDTH] is both the new X and the fill bit.
        x_d = sum[WIDTH];
        a_d = sum[WIDTH:1];
        b_d = {sum[0], b_q[WIDTH-1:1]};
      end
      OP_ARITH: begin
        x_d = sum[WIDTH];
        a_d = sum[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign M    = b_q[0];
  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed and randomized checks of mult_datapath against an integer-arithmetic reference model.
module tb_mult_datapath;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Clr_Ld = 1'b0;
  logic       Shift = 1'b0;
  logic       Add = 1'b0;
  logic       Sub = 1'b0;
  logic [7:0] S = 8'h00;
  logic       M;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;

  int n_pass = 0;
  int n_total = 0;

  // reference state
  logic       mx;
  logic [7:0] ma;
  logic [7:0] mb;

  mult_datapath #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clr_Ld (Clr_Ld),
    .Shift  (Shift),
    .Add    (Add),
    .Sub    (Sub),
    .S      (S),
    .M      (M),
    .Aval   (Aval),
    .Bval   (Bval),
    .X      (X)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".X"}, {15'd0, X}, {15'd0, mx});
    chk({tag, ".A"}, {8'd0, Aval}, {8'd0, ma});
    chk({tag, ".B"}, {8'd0, Bval}, {8'd0, mb});
    chk({tag, ".M"}, {15'd0, M}, {15'd0, mb[0]});
  endtask

  // Treat {X,A} as a 9-bit signed accumulator and {acc,B} as a 17-bit signed value.
  task automatic model_step(input bit clr, input bit sh, input bit ad, input bit sb,
                            input logic [7:0] s);
    int acc, av, sv, full;
    if (clr) begin
      mx = 1'b0;
      ma = 8'h00;
      mb = s;
      return;
    end
    av = $signed(ma);
    sv = $signed(s);
    if (sb && mb[0])      acc = av - sv;
    else if (ad && mb[0]) acc = av + sv;
    else                  acc = mx ? int'(ma) - 256 : int'(ma);
    if (sh) begin
      full = acc * 256 + int'(mb);
      full = full >>> 1;
      mb   = full[7:0];
      acc  = full >>> 8;
    end
    mx = (acc < 0);
    ma = acc[7:0];
  endtask

  task automatic step(input string tag, input bit clr, input bit sh, input bit ad,
                      input bit sb, input logic [7:0] s);
    Clr_Ld = clr;
    Shift  = sh;
    Add    = ad;
    Sub    = sb;
    S      = s;
    model_step(clr, sh, ad, sb, s);
    @(posedge Clk);
    #1;
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    mx = 1'b0;
    ma = 8'h00;
    mb = 8'h00;
    check_state(tag);
    #1;
    Reset = 1'b0;
  endtask

  task automatic multiply(input logic [7:0] mp, input logic [7:0] mc);
    int prod;
    step("mul.load", 1'b1, 1'b0, 1'b0, 1'b0, mp);
    for (int i = 0; i < 7; i++) step("mul.add", 1'b0, 1'b1, 1'b1, 1'b0, mc);
    step("mul.sub", 1'b0, 1'b1, 1'b0, 1'b1, mc);
    prod = int'($signed(mp)) * int'($signed(mc));
    chk("mul.product", {Aval, Bval}, prod[15:0]);
    chk("mul.sign", {15'd0, X}, {15'd0, prod < 0});
  endtask

  initial begin
    mx = 1'b0;
    ma = 8'h00;
    mb = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check_state("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Build X=1, A=0x12 then reset between edges.
    step("pre.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step("pre.add1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    step("pre.add2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h92);
    chk("pre.state", {7'd0, X, Aval}, 16'h0112);
    async_reset("async");

    // Clr_Ld outranks Shift.
    step("cl.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step("cl.add", 1'b0, 1'b0, 1'b1, 1'b0, 8'h12);
    step("cl.shift", 1'b1, 1'b1, 1'b0, 1'b0, 8'hC5);
    chk("cl.const", {6'd0, X, M, Aval}, 16'h0100);
    chk("cl.B", {8'd0, Bval}, 16'h00C5);

    // Shift+Add in one edge, then pure shift with M=0.
    step("sa.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step("sa.step", 1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
    chk("sa.const", {Aval, Bval}, 16'h0180);
    step("ps.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step("ps.step", 1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
    chk("ps.const", {Aval, Bval}, 16'h0000);

    // Sub alone, then Add+Sub (Sub wins).
    for (int k = 0; k < 2; k++) begin
      step("sub.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
      step("sub.add5", 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
      step("sub.sub", 1'b0, 1'b0, k[0], 1'b1, 8'h07);
      chk("sub.const", {7'd0, X, Aval}, 16'h01FE);
      chk("sub.B", {8'd0, Bval}, 16'h0001);
    end

    // Listed full multiplies.
    multiply(8'h07, 8'h03);
    chk("m1.const", {7'd0, X, Aval}, 16'h0000);
    multiply(8'h07, 8'hFD);
    chk("m2.const", {7'd0, X, Aval}, 16'h01FF);
    multiply(8'hF9, 8'h03);
    chk("m3.const", {Aval, Bval}, 16'hFFEB);
    multiply(8'hFF, 8'hFF);
    chk("m4.const", {Aval, Bval}, 16'h0001);
    multiply(8'h80, 8'h80);
    multiply(8'h80, 8'h7F);

    for (int i = 0; i < 20; i++) multiply(8'($urandom), 8'($urandom));

    // Random strobe soup with occasional asynchronous resets.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 29) == 0) async_reset("rnd.reset");
      step("rnd", $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom));
    end

    // Strobe held across cycles executes each cycle; reset mid-multiply.
    step("hold.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h6B);
    for (int i = 0; i < 3; i++) step("hold.add", 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    step("mid.shift", 1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
    async_reset("mid.reset");
    step("mid.idle", 1'b0, 1'b1, 1'b1, 1'b1, 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
